// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Holds widths, the iteration count, op encodings and FSM state encodings.
package muldiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned ITER  = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Iteration datapath: 64-bit accumulator, operand register, iteration counter
// and the per-cycle shift-add (multiply) or restoring-subtract (divide) step.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   load        capture magnitudes, clear upper accumulator and counter
//   step        perform one iteration
//   is_div      select divide step (1) or multiply step (0)
//   a_mag       multiplier / dividend magnitude
//   b_mag       multiplicand / divisor magnitude
//   acc         {upper, lower}: product, or {remainder, quotient}
//   last_c      current step is the final iteration
module muldiv_datapath
  import muldiv_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   a_mag,
  input  logic [WIDTH-1:0]   b_mag,
  output logic [2*WIDTH-1:0] acc,
  output logic               last_c
);

  logic [WIDTH-1:0]   opnd;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] acc_next;

  // Multiply keeps the multiplier in the low half and shifts it out LSB-first;
  // divide shifts the dividend out MSB-first while quotient bits shift in.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    rem_sub  = WIDTH'(trial - {1'b0, opnd});
    acc_next = acc;
    if (!is_div) begin
      acc_next = {mul_sum, acc[WIDTH-1:1]};
    end else if (trial >= {1'b0, opnd}) begin
      acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_next = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
  end

  assign last_c = (cnt == CNT_W'(ITER - 1));

  // Accumulator, operand and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc  <= '0;
      opnd <= '0;
      cnt  <= '0;
    end else if (load) begin
      acc  <= {{WIDTH{1'b0}}, a_mag};
      opnd <= b_mag;
      cnt  <= '0;
    end else if (step) begin
      acc  <= acc_next;
      cnt  <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO for the MIPS execute stage.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   start, op   request strobe and operation (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
//   a, b        rs / rt operands, used only on the accepting edge
//   busy        iterative operation in flight (issue must stall)
//   done        one-cycle pulse when HI/LO take an iterative result
//   div_zero    sticky: last DIV/DIVU had a zero divisor
//   hi, lo      HI / LO registers
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_e             state, state_next;
  logic               load, step, fix, wr_hi, wr_lo;
  logic               op_signed, op_div;
  logic               sign_q, sign_r, is_div_q;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               last_c;
  logic [WIDTH-1:0]   fix_hi, fix_lo;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

  muldiv_datapath u_datapath (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (load),
    .step   (step),
    .is_div (is_div_q),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .acc    (acc),
    .last_c (last_c)
  );

  // Next-state and control strobes.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    fix        = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              load       = 1'b1;
              state_next = S_CALC;
            end
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      S_CALC: begin
        step = 1'b1;
        if (last_c) state_next = S_FIX;
      end
      S_FIX: begin
        fix        = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Sign correction: a signed product negates as a whole 64-bit value,
  // quotient and remainder negate independently.
  always_comb begin
    {fix_hi, fix_lo} = acc;
    if (!is_div_q) begin
      if (sign_q) {fix_hi, fix_lo} = -acc;
    end else begin
      if (sign_q) fix_lo = -acc[WIDTH-1:0];
      if (sign_r) fix_hi = -acc[2*WIDTH-1:WIDTH];
    end
  end

  // State, sign latches and architectural outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      is_div_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_next;
      busy  <= (state_next != S_IDLE);
      done  <= fix;
      if (load) begin
        sign_q   <= op_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        sign_r   <= op_signed & a[WIDTH-1];
        is_div_q <= op_div;
        if (op_div) div_zero <= (b == '0);
      end
      if (fix) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
      if (wr_hi) hi <= a;
      if (wr_lo) lo <= a;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with literal results,
// then randomized traffic compared every cycle against a behavioural model.
module tb_muldiv_unit;

  localparam logic [2:0] T_MULT  = 3'd0;
  localparam logic [2:0] T_MULTU = 3'd1;
  localparam logic [2:0] T_DIV   = 3'd2;
  localparam logic [2:0] T_DIVU  = 3'd3;
  localparam logic [2:0] T_MTHI  = 3'd4;
  localparam logic [2:0] T_MTLO  = 3'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;

  muldiv_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: {hi, lo} an operation must leave behind.
  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    logic        sgn;
    longint      sx, sy;
    logic [31:0] am, bm, q, r;
    sgn = (o == T_MULT) || (o == T_DIV);
    if (o == T_MULT) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    if (o == T_MULTU) return {32'd0, x} * {32'd0, y};
    am = (sgn && x[31]) ? -x : x;
    bm = (sgn && y[31]) ? -y : y;
    q  = (bm == 0) ? 32'hFFFF_FFFF : am / bm;
    r  = (bm == 0) ? am : am % bm;
    if (sgn && (x[31] ^ y[31])) q = -q;
    if (sgn && x[31]) r = -r;
    return {r, q};
  endfunction

  // Cycle-level behavioural model of the visible state.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done, m_dz;
  logic [63:0] m_res;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi = 0; m_lo = 0; m_busy = 0; m_done = 0; m_dz = 0; m_left = 0; m_res = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          {m_hi, m_lo} = m_res;
          m_done = 1;
          m_busy = 0;
        end
      end else if (start) begin
        if (op <= T_DIVU) begin
          m_res  = ref_result(op, a, b);
          m_busy = 1;
          m_left = 33;
          if (op == T_DIV || op == T_DIVU) m_dz = (b == 0);
        end else if (op == T_MTHI) m_hi = a;
        else if (op == T_MTLO) m_lo = a;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy", 64'(busy), 64'(m_busy));
      chk("done", 64'(done), 64'(m_done));
      chk("div_zero", 64'(div_zero), 64'(m_dz));
      chk("hi", 64'(hi), 64'(m_hi));
      chk("lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 64'(busy), 64'(0));
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  int n;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; a = 0; b = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_hi", 64'(hi), 64'(0));
    chk("rst_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;

    do_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("multu_busy_cycles", 64'(n), 64'(33));
    chk("multu_done", 64'(done), 64'(1));
    chk("multu_hi", 64'(hi), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(lo), 64'h0000_0000_0000_0001);

    do_op(T_MULT, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    chk("mult_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(lo), 64'h0000_0000_FFFF_FFEB);

    do_op(T_DIV, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    chk("div_lo", 64'(lo), 64'h0000_0000_FFFF_FFFD);
    chk("div_hi", 64'(hi), 64'h0000_0000_FFFF_FFFF);
    chk("div_dz", 64'(div_zero), 64'(0));

    do_op(T_DIVU, 32'd100, 32'd0);
    wait_idle(n);
    chk("divz_lo", 64'(lo), 64'h0000_0000_FFFF_FFFF);
    chk("divz_hi", 64'(hi), 64'd100);
    chk("divz_dz", 64'(div_zero), 64'(1));
    do_op(T_DIVU, 32'd9, 32'd3);
    wait_idle(n);
    chk("divu_lo", 64'(lo), 64'd3);
    chk("divu_hi", 64'(hi), 64'd0);
    chk("divu_dz", 64'(div_zero), 64'(0));

    do_op(T_MTHI, 32'h1234_5678, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h0000_0000_1234_5678);
    chk("mthi_busy", 64'(busy), 64'(0));
    do_op(T_MTLO, 32'hCAFE_F00D, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h0000_0000_CAFE_F00D);

    do_op(T_MULT, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    start = 1'b1; op = T_MTHI; a = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    chk("mthi_ignored_hi", 64'(hi), 64'd0);
    chk("mthi_ignored_lo", 64'(lo), 64'd30);

    do_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_done", 64'(done), 64'(0));
    chk("arst_dz", 64'(div_zero), 64'(0));
    chk("arst_hi", 64'(hi), 64'(0));
    chk("arst_lo", 64'(lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    do_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    chk("ovf_lo", 64'(lo), 64'h0000_0000_8000_0000);
    chk("ovf_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      op    = 3'($urandom_range(0, 7));
      a     = pick();
      b     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    wait_idle(n);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
